// File: rtl/histogram_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : histogram_test_sequencer
//  Description : Launches NUM_RUNS decoding rounds after a warm-up delay with
//                a programmable gap between rounds. Each completed round
//                read-modify-writes one histogram bin (indexed by the reported
//                duration) in a 1-cycle-latency BRAM. At the end of the
//                campaign a completion marker is written for the ARM side.
//                Optional macro ERROR_SPLIT_HIST_EN splits each bin word into
//                a 24-bit round count [23:0] and an 8-bit error count [31:24].
//  Revision    : 1.0 - initial release
// ============================================================================
module histogram_test_sequencer #(
    parameter logic [31:0] NUM_RUNS      = 32'd10000,
    parameter logic [31:0] WARMUP_CYCLES = 32'hb0000000,
    parameter logic [31:0] GAP_CYCLES    = 32'd10,
    parameter logic [31:0] NUM_BINS      = 32'd1024,
    parameter logic [31:0] BIN_BASE      = 32'h4,
    parameter logic [31:0] DONE_ADDR     = 32'h0,
    parameter logic [31:0] DONE_MARKER   = 32'hffffffff
) (
    input  logic        clk,
    input  logic        reset,
    output logic        new_round_start,
    input  logic        result_valid,
    input  logic [31:0] duration,
    input  logic        error_detected,
    output logic [31:0] total_test_case_counter,
    output logic        done,
    output logic [3:0]  we,
    output logic        en,
    output logic [31:0] addr,
    output logic [31:0] di,
    input  logic [31:0] dout
);

    // Index of the last histogram bin; long rounds clamp into it.
    localparam logic [31:0] c_LAST_BIN = NUM_BINS - 32'd1;

    // Sequencer states
    localparam logic [2:0] c_SEQ_WARMUP = 3'd0;
    localparam logic [2:0] c_SEQ_RUN    = 3'd1;
    localparam logic [2:0] c_SEQ_GAP    = 3'd2;
    localparam logic [2:0] c_SEQ_FINISH = 3'd3;
    localparam logic [2:0] c_SEQ_HALT   = 3'd4;

    // Read-modify-write engine states
    localparam logic [2:0] c_RMW_IDLE  = 3'd0;
    localparam logic [2:0] c_RMW_READ  = 3'd1;
    localparam logic [2:0] c_RMW_LATCH = 3'd2;
    localparam logic [2:0] c_RMW_WRITE = 3'd3;
    localparam logic [2:0] c_RMW_MARK  = 3'd4;

    logic [2:0]  r_seq_state;
    logic [2:0]  r_rmw_state;
    logic [31:0] r_cnt;
    logic        r_rv_prev;
    logic        r_start;
    logic [31:0] r_total;
    logic        r_done;
    logic [3:0]  r_we;
    logic [31:0] r_addr;
    logic [31:0] r_di;

    logic        w_rise;
    logic        w_rmw_idle;
    logic        w_bin_req;
    logic        w_mark_req;
    logic [31:0] w_bin;
    logic [31:0] w_bin_addr;
    logic [31:0] w_launched;
    logic [31:0] w_next_word;

    assign new_round_start         = r_start;
    assign total_test_case_counter = r_total;
    assign done                    = r_done;
    assign we                      = r_we;
    assign en                      = 1'b1;
    assign addr                    = r_addr;
    assign di                      = r_di;

    // A round completes on the rising edge of the result level only.
    assign w_rise     = result_valid & ~r_rv_prev;
    assign w_rmw_idle = (r_rmw_state == c_RMW_IDLE);

    // A result edge is accepted only while the engine is free; otherwise it
    // is dropped and the sequencer keeps waiting in RUN.
    assign w_bin_req  = (r_seq_state == c_SEQ_RUN) & w_rise & w_rmw_idle;
    assign w_mark_req = (r_seq_state == c_SEQ_FINISH) & w_rmw_idle;

    assign w_bin      = (duration >= c_LAST_BIN) ? c_LAST_BIN : duration;
    assign w_bin_addr = BIN_BASE + (w_bin << 2);

    // Rounds launched including a start pulse still in flight, so an edge in
    // the pulse cycle itself cannot launch one round too many.
    assign w_launched = r_total + {31'd0, r_start};

`ifdef ERROR_SPLIT_HIST_EN
    logic        r_err;
    logic [23:0] w_round_field;
    logic [7:0]  w_err_field;

    assign w_round_field = (dout[23:0] == 24'hffffff) ? dout[23:0] : dout[23:0] + 24'd1;
    assign w_err_field   = (r_err && (dout[31:24] != 8'hff)) ? dout[31:24] + 8'd1 : dout[31:24];
    assign w_next_word   = {w_err_field, w_round_field};

    // Error flag captured together with the duration that selects the bin.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_bin_req) begin
            r_err <= error_detected;
        end
    end
`else
    logic w_unused_err;

    assign w_unused_err = error_detected;
    assign w_next_word  = (dout == 32'hffffffff) ? dout : dout + 32'd1;
`endif

    // Campaign sequencer: warm-up, round launch, gap timing and finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq_state <= c_SEQ_WARMUP;
            r_cnt       <= 32'd0;
            r_rv_prev   <= 1'b0;
            r_start     <= 1'b0;
            r_total     <= 32'd0;
        end else begin
            r_rv_prev <= result_valid;
            r_start   <= 1'b0;
            if (r_start && (r_total != NUM_RUNS)) begin
                r_total <= r_total + 32'd1;
            end
            case (r_seq_state)
                c_SEQ_WARMUP: begin
                    if (r_cnt == WARMUP_CYCLES) begin
                        r_start     <= 1'b1;
                        r_cnt       <= 32'd0;
                        r_seq_state <= c_SEQ_RUN;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_SEQ_RUN: begin
                    if (w_bin_req) begin
                        r_cnt       <= 32'd0;
                        r_seq_state <= (w_launched < NUM_RUNS) ? c_SEQ_GAP : c_SEQ_FINISH;
                    end
                end
                c_SEQ_GAP: begin
                    // The count stops at GAP_CYCLES and the launch waits there
                    // until the bin update has fully retired.
                    if (r_cnt == GAP_CYCLES) begin
                        if (w_rmw_idle) begin
                            r_start     <= 1'b1;
                            r_seq_state <= c_SEQ_RUN;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_SEQ_FINISH: begin
                    if (w_rmw_idle) begin
                        r_seq_state <= c_SEQ_HALT;
                    end
                end
                c_SEQ_HALT: begin
                    r_seq_state <= c_SEQ_HALT;
                end
                default: begin
                    r_seq_state <= c_SEQ_WARMUP;
                    r_cnt       <= 32'd0;
                end
            endcase
        end
    end

    // BRAM port engine: bin read-modify-write and the completion marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rmw_state <= c_RMW_IDLE;
            r_we        <= 4'h0;
            r_addr      <= BIN_BASE;
            r_di        <= 32'd0;
            r_done      <= 1'b0;
        end else begin
            case (r_rmw_state)
                c_RMW_IDLE: begin
                    if (w_bin_req) begin
                        r_addr      <= w_bin_addr;
                        r_rmw_state <= c_RMW_READ;
                    end else if (w_mark_req) begin
                        r_we        <= 4'hf;
                        r_addr      <= DONE_ADDR;
                        r_di        <= DONE_MARKER;
                        r_rmw_state <= c_RMW_MARK;
                    end
                end
                c_RMW_READ: begin
                    // Bin address is on the port this cycle; data returns next.
                    r_rmw_state <= c_RMW_LATCH;
                end
                c_RMW_LATCH: begin
                    // Read data is valid now: the incremented word goes
                    // straight into the write-data register.
                    r_we        <= 4'hf;
                    r_di        <= w_next_word;
                    r_rmw_state <= c_RMW_WRITE;
                end
                c_RMW_WRITE: begin
                    r_we        <= 4'h0;
                    r_addr      <= BIN_BASE;
                    r_di        <= 32'd0;
                    r_rmw_state <= c_RMW_IDLE;
                end
                c_RMW_MARK: begin
                    r_we        <= 4'h0;
                    r_addr      <= BIN_BASE;
                    r_di        <= 32'd0;
                    r_done      <= 1'b1;
                    r_rmw_state <= c_RMW_IDLE;
                end
                default: begin
                    r_we        <= 4'h0;
                    r_addr      <= BIN_BASE;
                    r_di        <= 32'd0;
                    r_rmw_state <= c_RMW_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_histogram_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_histogram_test_sequencer
//  Description : Directed self-checking bench for histogram_test_sequencer
//                with a behavioural 1-cycle-latency BRAM and decoder stub.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_histogram_test_sequencer;

    localparam logic [31:0] c_NUM_RUNS    = 32'd3;
    localparam logic [31:0] c_WARMUP      = 32'd20;
    localparam logic [31:0] c_GAP         = 32'd10;
    localparam logic [31:0] c_NUM_BINS    = 32'd1024;
    localparam logic [31:0] c_BIN_BASE    = 32'h4;
    localparam logic [31:0] c_DONE_ADDR   = 32'h0;
    localparam logic [31:0] c_DONE_MARKER = 32'hffffffff;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        result_valid = 1'b0;
    logic [31:0] duration = 32'd0;
    logic        error_detected = 1'b0;
    logic        new_round_start;
    logic [31:0] total_test_case_counter;
    logic        done;
    logic [3:0]  we;
    logic        en;
    logic [31:0] addr;
    logic [31:0] di;
    logic [31:0] dout;

    always #5 clk = ~clk;

    histogram_test_sequencer #(
        .NUM_RUNS      (c_NUM_RUNS),
        .WARMUP_CYCLES (c_WARMUP),
        .GAP_CYCLES    (c_GAP),
        .NUM_BINS      (c_NUM_BINS),
        .BIN_BASE      (c_BIN_BASE),
        .DONE_ADDR     (c_DONE_ADDR),
        .DONE_MARKER   (c_DONE_MARKER)
    ) u_dut (
        .clk                     (clk),
        .reset                   (reset),
        .new_round_start         (new_round_start),
        .result_valid            (result_valid),
        .duration                (duration),
        .error_detected          (error_detected),
        .total_test_case_counter (total_test_case_counter),
        .done                    (done),
        .we                      (we),
        .en                      (en),
        .addr                    (addr),
        .di                      (di),
        .dout                    (dout)
    );

    // Behavioural BRAM, word-indexed by addr[12:2], read-first.
    logic [31:0] mem [0:2047];
    logic        mem_init = 1'b0;
    logic [10:0] pre_idx0 = 11'd0;
    logic [31:0] pre_val0 = 32'd0;
    logic [10:0] pre_idx1 = 11'd0;
    logic [31:0] pre_val1 = 32'd0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'd0;
            mem[pre_idx0] <= pre_val0;
            mem[pre_idx1] <= pre_val1;
        end else if (en && (we == 4'hf)) begin
            mem[addr[12:2]] <= di;
        end
        dout <= mem[addr[12:2]];
    end

    // Cycle index: 0 in the cycle after the first rising edge out of reset.
    int edge_idx;
    always @(posedge clk) begin
        if (reset) edge_idx <= -1;
        else       edge_idx <= edge_idx + 1;
    end

    // Output monitor sampled on the falling edge.
    int   pulse_cnt;
    int   pulse_cyc [0:8];
    int   last_edge_cyc;
    int   min_gap;
    int   lat_bad;
    int   wr_cnt;
    int   bin_wr_cnt;
    int   oob_cnt;
    logic mon_rv_prev;

    always @(negedge clk) begin
        if (reset) begin
            pulse_cnt     <= 0;
            for (int i = 0; i <= 8; i++) pulse_cyc[i] <= -1;
            last_edge_cyc <= -1000;
            min_gap       <= 1000000;
            lat_bad       <= 0;
            wr_cnt        <= 0;
            bin_wr_cnt    <= 0;
            oob_cnt       <= 0;
            mon_rv_prev   <= 1'b0;
        end else begin
            mon_rv_prev <= result_valid;
            if (result_valid && !mon_rv_prev) last_edge_cyc <= edge_idx;
            if (new_round_start) begin
                pulse_cnt <= pulse_cnt + 1;
                if (pulse_cnt < 8) pulse_cyc[pulse_cnt + 1] <= edge_idx;
                if ((pulse_cnt >= 1) && (edge_idx - last_edge_cyc < min_gap))
                    min_gap <= edge_idx - last_edge_cyc;
            end
            if (we != 4'h0) begin
                wr_cnt <= wr_cnt + 1;
                if (addr != c_DONE_ADDR) begin
                    bin_wr_cnt <= bin_wr_cnt + 1;
                    if (edge_idx - last_edge_cyc != 3) lat_bad <= lat_bad + 1;
                end
                if (!((addr == c_DONE_ADDR) ||
                      ((addr >= c_BIN_BASE) && (addr <= 32'h1000) && (addr[1:0] == 2'b00))))
                    oob_cnt <= oob_cnt + 1;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset        = 1'b1;
        result_valid = 1'b0;
        mem_init     = 1'b1;
        tick();
        mem_init = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_pulse(input int k);
        int t;
        t = 0;
        while ((pulse_cnt < k) && (t < 3000)) begin
            tick();
            t++;
        end
        if (pulse_cnt < k) check("pulse_timeout", pulse_cnt, k);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && (t < 3000)) begin
            tick();
            t++;
        end
        check("done", {31'd0, done}, 32'd1);
    endtask

    task automatic respond(input logic [31:0] dur, input logic err, input int delay, input int hold);
        repeat (delay) tick();
        duration       = dur;
        error_detected = err;
        result_valid   = 1'b1;
        repeat (hold) tick();
        result_valid = 1'b0;
    endtask

    task automatic run_round(input int k, input logic [31:0] dur, input logic err, input int hold);
        wait_pulse(k);
        respond(dur, err, 3, hold);
    endtask

    initial begin
        // Reset values while reset is held
        reset = 1'b1;
        mem_init = 1'b1;
        tick();
        tick();
        mem_init = 1'b0;
        check("rst_start", {31'd0, new_round_start}, 32'd0);
        check("rst_total", total_test_case_counter, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_we",    {28'd0, we}, 32'd0);
        check("rst_addr",  addr, c_BIN_BASE);
        check("rst_di",    di, 32'd0);
        check("rst_en",    {31'd0, en}, 32'd1);
        tick();
        reset = 1'b0;

        // Basic campaign: three rounds of duration 5
        run_round(1, 32'd5, 1'b0, 4);
        run_round(2, 32'd5, 1'b0, 4);
        run_round(3, 32'd5, 1'b0, 4);
        wait_done();
        check("a_first_pulse", pulse_cyc[1], 32'd20);
        check("a_bin5",        mem[6], 32'd3);
        check("a_marker",      mem[0], 32'hffffffff);
        check("a_total",       total_test_case_counter, 32'd3);
        check("a_pulses",      pulse_cnt, 32'd3);
        check("a_gap_ok",      {31'd0, (min_gap >= 11)}, 32'd1);
        check("a_latency_bad", lat_bad, 32'd0);
        // Edges after the campaign are ignored
        respond(32'd5, 1'b0, 1, 3);
        repeat (10) tick();
        check("a_halt_writes", wr_cnt, 32'd4);
        check("a_halt_pulses", pulse_cnt, 32'd3);
        check("a_halt_bin5",   mem[6], 32'd3);
        check("a_done_sticky", {31'd0, done}, 32'd1);

        // Clamping into the last bin
        do_reset();
        run_round(1, 32'd5000, 1'b0, 4);
        run_round(2, 32'd1023, 1'b0, 4);
        run_round(3, 32'd0, 1'b0, 4);
        wait_done();
        check("b_bin1023", mem[1024], 32'd2);
        check("b_bin0",    mem[1], 32'd1);
        check("b_beyond",  mem[1025], 32'd0);
        check("b_oob",     oob_cnt, 32'd0);
        check("b_marker",  mem[0], 32'hffffffff);

        // Saturation at all-ones
        pre_idx0 = 11'd6; pre_val0 = 32'hffffffff;
        pre_idx1 = 11'd7; pre_val1 = 32'hfffffffe;
        do_reset();
        run_round(1, 32'd5, 1'b0, 4);
        run_round(2, 32'd6, 1'b0, 4);
        run_round(3, 32'd6, 1'b0, 4);
        wait_done();
        check("c_sat_bin5", mem[6], 32'hffffffff);
        check("c_sat_bin6", mem[7], 32'hffffffff);
        check("c_bin7",     mem[8], 32'd0);
        pre_idx0 = 11'd0; pre_val0 = 32'd0;
        pre_idx1 = 11'd0; pre_val1 = 32'd0;

        // Level held high: one update per rising edge
        do_reset();
        run_round(1, 32'd9, 1'b0, 50);
        run_round(2, 32'd9, 1'b0, 4);
        run_round(3, 32'd9, 1'b0, 4);
        wait_done();
        check("d_bin9",    mem[10], 32'd3);
        check("d_bin_wr",  bin_wr_cnt, 32'd3);
        check("d_pulses",  pulse_cnt, 32'd3);
        check("d_gap_ok",  {31'd0, (min_gap >= 11)}, 32'd1);
        check("d_total",   total_test_case_counter, 32'd3);

        // Reset during LATCH of round 2
        do_reset();
        run_round(1, 32'd3, 1'b0, 4);
        wait_pulse(2);
        tick();
        duration     = 32'd3;
        result_valid = 1'b1;
        tick();
        tick();
        check("e_latch_addr", addr, 32'h10);
        check("e_latch_we",   {28'd0, we}, 32'd0);
        reset        = 1'b1;
        result_valid = 1'b0;
        tick();
        check("e_rst_we",    {28'd0, we}, 32'd0);
        check("e_rst_addr",  addr, c_BIN_BASE);
        check("e_rst_di",    di, 32'd0);
        check("e_rst_start", {31'd0, new_round_start}, 32'd0);
        check("e_rst_total", total_test_case_counter, 32'd0);
        check("e_rst_done",  {31'd0, done}, 32'd0);
        tick();
        tick();
        check("e_bin3", mem[4], 32'd1);
        reset = 1'b0;
        wait_pulse(1);
        check("e_restart_pulse", pulse_cyc[1], 32'd20);

        // Error-flag handling
        do_reset();
        run_round(1, 32'd7, 1'b1, 4);
        run_round(2, 32'd7, 1'b0, 4);
        run_round(3, 32'd2, 1'b1, 4);
        wait_done();
`ifdef ERROR_SPLIT_HIST_EN
        check("f_bin7", mem[8], 32'h01000002);
        check("f_bin2", mem[3], 32'h01000001);
`else
        check("f_bin7", mem[8], 32'd2);
        check("f_bin2", mem[3], 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/histogram_test_sequencer.md
Name: histogram_test_sequencer

Overview:
- Parametrised successor to the test-round controller.
- Launches NUM_RUNS decoding rounds after a warm-up delay, with a programmable gap between rounds.
- On each completed round, read-modify-writes one histogram bin in a 1-cycle-latency BRAM, indexed by the reported duration.
- At end of campaign, writes a completion marker that the ARM side polls.
- Sits between the decoder top level (round start / result) and the AXI BRAM port shared with the processor.

Parameters:
- NUM_RUNS, 10000: rounds per campaign.
- WARMUP_CYCLES, 32'hb0000000: idle cycles after reset before the first round.
- GAP_CYCLES, 10: idle cycles between a result and the next round start; legal minimum is 4.
- NUM_BINS, 1024: histogram bins; durations ≥ NUM_BINS-1 clamp into the last bin.
- BIN_BASE, 32'h4: byte address of bin 0.
- DONE_ADDR, 32'h0: byte address of the completion marker.
- DONE_MARKER, 32'hffffffff: value written to DONE_ADDR.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- new_round_start  out  1  one-cycle pulse that starts a decoding round.
- result_valid  in  1  level from decoder; its rising edge marks round completion.
- duration  in  32  cycles taken by the round; sampled on the result_valid rising edge.
- error_detected  in  1  logical-error flag; sampled with duration.
- total_test_case_counter  out  32  rounds launched so far.
- done  out  1  high once the marker write has completed; sticky until reset.
- we  out  4  BRAM byte write enables.
- en  out  1  BRAM enable; tied to 1.
- addr  out  32  BRAM byte address.
- di  out  32  BRAM write data.
- dout  in  32  BRAM read data, valid 1 cycle after addr.

Behaviour:
- Reset values: new_round_start=0, total_test_case_counter=0, done=0, we=0, addr=BIN_BASE, di=0. Both FSMs return to their initial state. Reset mid-campaign or mid-RMW aborts immediately; no partial write is issued.
- Sequencer FSM states: WARMUP, RUN, GAP, FINISH, HALT.
  - WARMUP: counter increments from 0. When it reaches WARMUP_CYCLES, pulse new_round_start and go to RUN.
  - RUN: wait for a result_valid rising edge (current 1, previous cycle 0). A level held high produces no further events.
    - On the edge, capture duration and error_detected, and request an RMW.
    - Next state is GAP if total_test_case_counter < NUM_RUNS, else FINISH.
  - GAP: counter counts 0..GAP_CYCLES. Pulse new_round_start only when the count has expired AND the RMW engine is idle; otherwise wait. Then go to RUN.
  - FINISH: once the RMW engine is idle, request the marker write, then go to HALT.
  - HALT: terminal until reset. Further result_valid edges are ignored.
- total_test_case_counter increments in the cycle after each new_round_start pulse. It never exceeds NUM_RUNS.
- Bin index: bin = (captured duration ≥ NUM_BINS-1) ? NUM_BINS-1 : captured duration. addr = BIN_BASE + bin*4, using a 32-bit unsigned product.
- RMW engine states: IDLE, READ, LATCH, WRITE, MARK.
  - IDLE: addr = BIN_BASE. A request moves to READ.
  - READ: drive the bin addr.
  - LATCH: addr held; capture dout.
  - WRITE: we=4'hF, di = captured+1, saturating at 32'hffffffff (no wrap). Return to IDLE.
  - MARK: we=4'hF, addr=DONE_ADDR, di=DONE_MARKER. Set done next cycle.
- Latency: the bin write occurs 3 cycles after the result_valid edge.
- A result_valid edge arriving while the RMW engine is busy cannot occur in legal operation, given GAP_CYCLES ≥ 4. If it does occur, it is dropped and the sequencer stays in RUN.
- we=0 in every state other than WRITE and MARK.

Optional Feature:
- Macro ERROR_SPLIT_HIST_EN.
- With the macro defined, WRITE updates the bin word as two fields:
  - [23:0] = round count, +1, saturating at 24'hffffff.
  - [31:24] = error count, +1 only when the captured error_detected=1, saturating at 8'hff.
- Without the macro, the full 32-bit word is a saturating round count and error_detected is ignored.

Test Plan:
- WARMUP_CYCLES=20, GAP_CYCLES=10, NUM_RUNS=3: first new_round_start pulse in cycle 20 after reset release. Answer each round with duration=5 → bin at addr 0x18 reads 3; marker 0xffffffff at addr 0; done=1; total_test_case_counter=3; exactly 3 pulses.
- duration=5000 with NUM_BINS=1024 → bin 1023 (addr 0x1000) increments; no write outside the bin range.
- Preload bin 5 with 0xffffffff, round with duration=5 → value stays 0xffffffff.
- result_valid held high for 50 cycles → a single RMW; each subsequent pulse follows the previous edge by ≥ GAP_CYCLES+1 cycles.
- Assert reset during the LATCH state of round 2 → no write that cycle; all outputs at reset values; campaign restarts with WARMUP.
- ERROR_SPLIT_HIST_EN defined, two rounds with duration=7 and error_detected=1 then 0 → bin 7 = 0x01000002.
